// File: rtl/ccr_unit_if.sv
// ----------------------------------------------------------------------------
// ccr_unit_if : bundle of the flag, write and condition signals around the
//               68000 Condition Code Register unit.
//
// master modport (sequencer / Alu side) drives:
//   c, z, v, n      Alu carry, zero, overflow and sign flags
//   upd_en          latch Alu flags this cycle
//   upd_mask[4:0]   per-bit update enable, order {X,N,Z,V,C}
//   sticky_z        ADDX/SUBX/NEGX Z rule (Z may only clear)
//   wr_en           explicit CCR write this cycle
//   wr_op[1:0]      0=MOVE, 1=AND, 2=OR, 3=EOR
//   wr_data[bits]   operand, only [4:0] is meaningful
//   cond_valid      condition evaluation request
//   cond[3:0]       68000 condition code
// slave modport (ccr_unit) drives:
//   cond_done       one-cycle pulse, result valid
//   cond_true       condition result, held until the next cond_done
//   ccr[4:0]        current {X,N,Z,V,C}
//   x               ccr[4], to the Alu extend input
// ----------------------------------------------------------------------------
interface ccr_unit_if #(
  parameter int bits = 16
);
  logic            c;
  logic            z;
  logic            v;
  logic            n;
  logic            upd_en;
  logic [4:0]      upd_mask;
  logic            sticky_z;
  logic            wr_en;
  logic [1:0]      wr_op;
  logic [bits-1:0] wr_data;
  logic            cond_valid;
  logic [3:0]      cond;
  logic            cond_done;
  logic            cond_true;
  logic [4:0]      ccr;
  logic            x;

  modport master (
    output c, z, v, n, upd_en, upd_mask, sticky_z,
    output wr_en, wr_op, wr_data, cond_valid, cond,
    input  cond_done, cond_true, ccr, x
  );

  modport slave (
    input  c, z, v, n, upd_en, upd_mask, sticky_z,
    input  wr_en, wr_op, wr_data, cond_valid, cond,
    output cond_done, cond_true, ccr, x
  );
endinterface

// File: rtl/ccr_unit.sv
// ----------------------------------------------------------------------------
// ccr_unit : 68000 Condition Code Register {X,N,Z,V,C}.
//   - Latches Alu flags under a per-bit mask (with the sticky-Z rule used by
//     ADDX/SUBX/NEGX), or executes MOVE/ANDI/ORI/EORI to CCR. An explicit
//     write has priority over a flag update in the same cycle.
//   - Evaluates the 16 Bcc/Scc/DBcc conditions with one cycle of latency,
//     fully pipelined; cond_true holds until the next cond_done.
//   - x mirrors ccr[4] for the Alu extend input.
//
// Ports:
//   CLK      system clock, rising edge
//   RESET_N  asynchronous active-low reset
//   bus      ccr_unit_if.slave (see rtl/ccr_unit_if.sv for the signal list)
//
// Build option:
//   CCR_BYPASS_EN  when defined, conditions are evaluated against the
//                  next-state CCR (same-cycle update/write included), so a
//                  Bcc may directly follow a flag-setting op. When undefined,
//                  the registered CCR is used.
// ----------------------------------------------------------------------------
module ccr_unit #(
  parameter int bits = 16
) (
  input  logic      CLK,
  input  logic      RESET_N,
  ccr_unit_if.slave bus
);

  localparam logic [1:0] OP_MOVE = 2'd0;
  localparam logic [1:0] OP_AND  = 2'd1;
  localparam logic [1:0] OP_OR   = 2'd2;
  localparam logic [1:0] OP_EOR  = 2'd3;

  logic [4:0] ccr_r;
  logic       cond_done_r;
  logic       cond_true_r;

  logic [4:0] upd_ccr_s;
  logic [4:0] wr_ccr_s;
  logic [4:0] next_ccr_s;
  logic [4:0] eval_ccr_s;
  logic       unused_wr_data_s;

  // 68000 condition table; takes {N,Z,V,C} only, X never affects a condition.
  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] nzvc);
    logic f_n;
    logic f_z;
    logic f_v;
    logic f_c;
    logic res;
    f_n = nzvc[3];
    f_z = nzvc[2];
    f_v = nzvc[1];
    f_c = nzvc[0];
    case (cc)
      4'h0:    res = 1'b1;
      4'h1:    res = 1'b0;
      4'h2:    res = ~f_c & ~f_z;
      4'h3:    res = f_c | f_z;
      4'h4:    res = ~f_c;
      4'h5:    res = f_c;
      4'h6:    res = ~f_z;
      4'h7:    res = f_z;
      4'h8:    res = ~f_v;
      4'h9:    res = f_v;
      4'hA:    res = ~f_n;
      4'hB:    res = f_n;
      4'hC:    res = f_n ~^ f_v;
      4'hD:    res = f_n ^ f_v;
      4'hE:    res = ~f_z & (f_n ~^ f_v);
      4'hF:    res = f_z | (f_n ^ f_v);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Only wr_data[4:0] maps onto the CCR; fold the rest away.
  assign unused_wr_data_s = ^bus.wr_data[bits-1:5];

  // Masked Alu flag update; X copies the carry, Z may only clear when sticky.
  always_comb begin
    upd_ccr_s    = ccr_r;
    upd_ccr_s[4] = bus.upd_mask[4] ? bus.c : ccr_r[4];
    upd_ccr_s[3] = bus.upd_mask[3] ? bus.n : ccr_r[3];
    if (bus.upd_mask[2]) begin
      upd_ccr_s[2] = bus.sticky_z ? (ccr_r[2] & bus.z) : bus.z;
    end else begin
      upd_ccr_s[2] = ccr_r[2];
    end
    upd_ccr_s[1] = bus.upd_mask[1] ? bus.v : ccr_r[1];
    upd_ccr_s[0] = bus.upd_mask[0] ? bus.c : ccr_r[0];
  end

  // Explicit MOVE/ANDI/ORI/EORI to CCR result.
  always_comb begin
    wr_ccr_s = ccr_r;
    case (bus.wr_op)
      OP_MOVE: wr_ccr_s = bus.wr_data[4:0];
      OP_AND:  wr_ccr_s = ccr_r & bus.wr_data[4:0];
      OP_OR:   wr_ccr_s = ccr_r | bus.wr_data[4:0];
      OP_EOR:  wr_ccr_s = ccr_r ^ bus.wr_data[4:0];
      default: wr_ccr_s = ccr_r;
    endcase
  end

  // Next-state select: an explicit write overrides a same-cycle flag update.
  always_comb begin
    next_ccr_s = ccr_r;
    if (bus.wr_en) begin
      next_ccr_s = wr_ccr_s;
    end else if (bus.upd_en) begin
      next_ccr_s = upd_ccr_s;
    end else begin
      next_ccr_s = ccr_r;
    end
  end

`ifdef CCR_BYPASS_EN
  assign eval_ccr_s = next_ccr_s;
`else
  assign eval_ccr_s = ccr_r;
`endif

  // CCR register plus the registered condition result and its done pulse.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ccr_r       <= 5'b00000;
      cond_done_r <= 1'b0;
      cond_true_r <= 1'b0;
    end else begin
      ccr_r       <= next_ccr_s;
      cond_done_r <= bus.cond_valid;
      if (bus.cond_valid) begin
        cond_true_r <= cond_eval(bus.cond, eval_ccr_s[3:0]);
      end else begin
        cond_true_r <= cond_true_r;
      end
    end
  end

  assign bus.ccr       = ccr_r;
  assign bus.x         = ccr_r[4];
  assign bus.cond_done = cond_done_r;
  assign bus.cond_true = cond_true_r;

endmodule
